// File: rtl/spram_ctrl_pkg.sv
// Shared types and constants for the single-port RAM request controller.
// Holds the controller state encoding and the response FIFO sizing.
// No logic; imported by the controller and its response FIFO.
package spram_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int RESP_FIFO_DEPTH = 2;
    localparam int RESP_CNT_W      = $clog2(RESP_FIFO_DEPTH + 1);

endpackage

// File: rtl/spram_resp_fifo.sv
// Two-entry in-order buffer for RAM read data awaiting the client.
// Latency: pushed word is visible at the head the cycle after the push.
// Backpressure: pop only when non-empty; the controller guarantees it never pushes into a full buffer.
module spram_resp_fifo
    import spram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [RESP_CNT_W-1:0] count
);

    localparam int PW = $clog2(RESP_FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [RESP_FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop    = pop && (count != '0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push   = push && ((count != RESP_CNT_W'(RESP_FIFO_DEPTH)) || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + RESP_CNT_W'(do_push) - RESP_CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/spram_req_ctrl.sv
// Client request front-end for a 1-cycle-latency single-port RAM, with full-RAM zeroing on reset/clear.
// Latency: reads return at t+2 through a 2-entry response FIFO; writes are posted.
// Backpressure: req_ready_o drops when buffered plus in-flight reads would exceed the FIFO, during CLEAR, or with a clear pending.
module spram_req_ctrl
    import spram_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DATA_DEPTH = 1024,
    parameter  int BYTE_SIZE  = 8,
    localparam int AW         = $clog2(DATA_DEPTH),
    localparam int NB         = DATA_WIDTH / BYTE_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [NB-1:0]         req_we_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    input  logic                  clear_i,
    output logic                  clear_busy_o,
    output logic [AW-1:0]         ram_addr_o,
    output logic [NB-1:0]         ram_we_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    state_t                state_q;
    state_t                state_d;
    logic [AW-1:0]         cnt_q;
    logic                  inflight_q;
    logic                  clr_pend_q;
    logic [RESP_CNT_W-1:0] fifo_count;
    logic                  fifo_pop;
    logic [RESP_CNT_W:0]   occupancy;
    logic                  req_acc;
    logic                  rd_acc;
    logic                  clr_acc;
    logic                  clr_last;

    assign resp_valid_o = (fifo_count != '0);
    assign fifo_pop     = resp_valid_o && resp_ready_i;
    assign clear_busy_o = (state_q == CLEAR);

    // Slots already committed: buffered words plus the read whose data lands next cycle, minus the one leaving now.
    assign occupancy   = (RESP_CNT_W+1)'(fifo_count) + (RESP_CNT_W+1)'(inflight_q)
                       - (RESP_CNT_W+1)'(fifo_pop);
    assign req_ready_o = (state_q == RUN) && !clr_pend_q
                      && (occupancy < (RESP_CNT_W+1)'(RESP_FIFO_DEPTH));

    assign req_acc  = req_valid_i && req_ready_o;
    assign rd_acc   = req_acc && (req_we_i == '0);
    assign clr_acc  = (state_q == RUN) && (clear_i || clr_pend_q) && !inflight_q && !req_acc;
    assign clr_last = (cnt_q == AW'(DATA_DEPTH - 1));

    always_comb begin
        state_d     = state_q;
        ram_addr_o  = req_addr_i;
        ram_we_o    = '0;
        ram_wdata_o = req_wdata_i;
        case (state_q)
            CLEAR: begin
                ram_addr_o  = cnt_q;
                ram_we_o    = '1;
                ram_wdata_o = '0;
                if (clr_last) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (req_acc) begin
                    ram_we_o = req_we_i;
                end
                if (clr_acc) begin
                    state_d = CLEAR;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= (state_q == CLEAR && !clr_last) ? cnt_q + AW'(1) : '0;
            inflight_q <= rd_acc;
            clr_pend_q <= (state_q == RUN) && (clear_i || clr_pend_q) && !clr_acc;
        end
    end

    spram_resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (ram_rdata_i),
        .pop       (fifo_pop),
        .head_data (resp_rdata_o),
        .count     (fifo_count)
    );

endmodule
